data_mem: RTL and testbench

//  Word-addressed data memory with a ready/valid read path and configurable read latency.

---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/data_mem_array.sv | 39 +++
 rtl/data_mem.sv | 131 +++++++++++++
 tb/tb_data_mem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: word width, address decode, FSM states.
package rv_defs;

   localparam int WORD_W   = 32;
   localparam int ADDR_LSB = 2;
   localparam int IDX_W    = WORD_W - ADDR_LSB;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic             misaligned;
      logic [IDX_W-1:0] index;
   } addr_dec_t;

   // Split a byte address into its word index and a misalignment flag
   function automatic addr_dec_t addr_decode(input logic [WORD_W-1:0] addr);
      addr_dec_t d;
      d.misaligned = |addr[ADDR_LSB-1:0];
      d.index      = addr[WORD_W-1:ADDR_LSB];
      return d;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with one write port and one registered read port.
module dmem_array
   import rv_defs::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic              clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic              i_rd_en,
   input  logic              i_rd_zero,
   input  logic [AW-1:0]     i_idx,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_rdata;

   // Storage is never cleared; only qualified writes touch it
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_idx] <= i_wdata;
      end
   end

   // Capture the read word at the accept edge; bad addresses read as zero
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_rd_en) begin
         r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem.sv
// Data memory front end: request accept, address check, read latency FSM and output pipe.
module data_mem
   import rv_defs::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemCE_i,
   input  logic              MemWE_i,
   input  logic [WORD_W-1:0] MemAddr_i,
   input  logic [WORD_W-1:0] MemData_i,
   output logic              Ready_o,
   output logic              RdValid_o,
   output logic [WORD_W-1:0] MemData_o,
   output logic              Err_o
);

   localparam int               AW       = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] IDX_LIM  = IDX_W'(DEPTH_WORDS);
   localparam logic [1:0]       CNT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_cnt;
   logic [1:0]        w_cnt_nxt;
   logic              r_ld_err;
   addr_dec_t         w_dec;
   logic              w_bad;
   logic              w_accept;
   logic              w_acc_ld;
   logic              w_acc_st;
   logic              w_wr_en;
   logic              w_fire;
   logic [WORD_W-1:0] w_rd_data;

   assign w_dec    = addr_decode(MemAddr_i);
   assign w_bad    = w_dec.misaligned | (w_dec.index >= IDX_LIM);
   assign Ready_o  = (r_state == IDLE);
   // Ready_o is 1 throughout reset, so rst also gates acceptance to keep requests out
   assign w_accept = MemCE_i & Ready_o & rst;
   assign w_acc_ld = w_accept & ~MemWE_i;
   assign w_acc_st = w_accept & MemWE_i;
   assign w_wr_en  = w_acc_st & ~w_bad;
   // Final WAIT cycle: the next edge delivers the load
   assign w_fire   = (r_state == WAIT) && (r_cnt == 2'd0);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk       (clk),
      .i_rst_n   (rst),
      .i_wr_en   (w_wr_en),
      .i_rd_en   (w_acc_ld),
      .i_rd_zero (w_bad),
      .i_idx     (w_dec.index[AW-1:0]),
      .i_wdata   (MemData_i),
      .o_rdata   (w_rd_data)
   );

   // Next-state and latency counter for multi-cycle loads
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_acc_ld && (RD_LATENCY > 1)) begin
               w_state_nxt = WAIT;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         WAIT: begin
            if (r_cnt == 2'd0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 2'd0;
         end
      endcase
   end

   // State register; reset aborts any outstanding read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Valid and error strobes, plus the load error held until its data is delivered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RdValid_o <= 1'b0;
         Err_o     <= 1'b0;
         r_ld_err  <= 1'b0;
      end else begin
         if (w_acc_ld) begin
            r_ld_err <= w_bad;
         end
         RdValid_o <= (RD_LATENCY == 1) ? w_acc_ld : w_fire;
         Err_o     <= (w_acc_st & w_bad) |
                      ((RD_LATENCY == 1) ? (w_acc_ld & w_bad) : (w_fire & r_ld_err));
      end
   end

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         // Array read register already updates only on loads and holds otherwise
         assign MemData_o = w_rd_data;
      end else begin : g_latn
         // Output register loads the captured word on the delivery edge and holds after
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               MemData_o <= '0;
            end else if (w_fire) begin
               MemData_o <= w_rd_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: one DUT at read latency 2, one at read latency 1.
module tb_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce2, we2, rdy2, vld2, err2;
   logic [31:0] addr2, wd2, rd2;
   logic        ce1, we1, rdy1, vld1, err1;
   logic [31:0] addr1, wd1, rd1;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   data_mem #(.DEPTH_WORDS(64), .RD_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .MemCE_i(ce2), .MemWE_i(we2), .MemAddr_i(addr2), .MemData_i(wd2),
      .Ready_o(rdy2), .RdValid_o(vld2), .MemData_o(rd2), .Err_o(err2));

   data_mem #(.DEPTH_WORDS(64), .RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .MemCE_i(ce1), .MemWE_i(we1), .MemAddr_i(addr1), .MemData_i(wd1),
      .Ready_o(rdy1), .RdValid_o(vld1), .MemData_o(rd1), .Err_o(err1));

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store2(input logic [31:0] a, input logic [31:0] d);
      ce2 = 1'b1; we2 = 1'b1; addr2 = a; wd2 = d;
      tick();
      ce2 = 1'b0; we2 = 1'b0;
   endtask

   task automatic load2(input logic [31:0] a);
      ce2 = 1'b1; we2 = 1'b0; addr2 = a;
      tick();
      ce2 = 1'b0;
   endtask

   task automatic test_reset();
      store2(32'h20, 32'h1111_1111);
      rst = 1'b0;
      ce2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wd2 = 32'hFFFF_FFFF;
      ce1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
      tick();
      tick();
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL rst_ready2: got %b want 1", rdy2); end
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL rst_valid2: got %b want 0", vld2); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_data2: got %h want 00000000", rd2); end
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL rst_err2: got %b want 0", err2); end
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b want 1", rdy1); end
      checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b want 0", vld1); end
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_data1: got %h want 00000000", rd1); end
      ce2 = 1'b0; we2 = 1'b0; ce1 = 1'b0;
      rst = 1'b1;
      tick();
      load2(32'h20);
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL rst_nowrite_vld: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'h1111_1111) begin errors++; $display("FAIL rst_nowrite_data: got %h want 11111111", rd2); end
   endtask

   task automatic test_store_load();
      store2(32'h10, 32'hDEAD_BEEF);
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL st_err: got %b want 0", err2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL st_ready: got %b want 1", rdy2); end
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL st_valid: got %b want 0", vld2); end
      load2(32'h10);
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL ld_busy_ready: got %b want 0", rdy2); end
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL ld_early_valid: got %b want 0", vld2); end
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL ld_valid: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_data: got %h want deadbeef", rd2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL ld_ready_back: got %b want 1", rdy2); end
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL ld_err: got %b want 0", err2); end
      tick();
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL ld_one_cycle: got %b want 0", vld2); end
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_hold: got %h want deadbeef", rd2); end
   endtask

   task automatic test_misaligned();
      load2(32'h13);
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL mis_ld_valid: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL mis_ld_data: got %h want 00000000", rd2); end
      checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL mis_ld_err: got %b want 1", err2); end
      tick();
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL mis_ld_err_pulse: got %b want 0", err2); end
      store2(32'h12, 32'hCAFE_F00D);
      checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL mis_st_err: got %b want 1", err2); end
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL mis_st_valid: got %b want 0", vld2); end
      tick();
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL mis_st_err_pulse: got %b want 0", err2); end
      load2(32'h10);
      tick();
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mis_st_nowrite: got %h want deadbeef", rd2); end
   endtask

   task automatic test_out_of_range();
      store2(32'h0, 32'hA5A5_A5A5);
      store2(32'h100, 32'h1234_5678);
      checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL oor_st_err: got %b want 1", err2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL oor_st_ready: got %b want 1", rdy2); end
      load2(32'h0);
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL oor_st_err_pulse: got %b want 0", err2); end
      tick();
      checks++; if (rd2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL oor_st_nowrite: got %h want a5a5a5a5", rd2); end
      load2(32'h100);
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL oor_ld_valid: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL oor_ld_data: got %h want 00000000", rd2); end
      checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL oor_ld_err: got %b want 1", err2); end
      store2(32'hFC, 32'h0BAD_F00D);
      checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL last_word_st_err: got %b want 0", err2); end
      load2(32'hFC);
      tick();
      checks++; if (rd2 !== 32'h0BAD_F00D) begin errors++; $display("FAIL last_word_data: got %h want 0badf00d", rd2); end
   endtask

   task automatic test_reset_mid_read();
      load2(32'h10);
      #2 rst = 1'b0;
      #1;
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", rdy2); end
      tick();
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL abort_valid_in_rst: got %b want 0", vld2); end
      rst = 1'b1;
      tick();
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL abort_valid_after: got %b want 0", vld2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL abort_ready_after: got %b want 1", rdy2); end
      load2(32'h10);
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL abort_reload_valid: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL abort_reload_data: got %h want deadbeef", rd2); end
   endtask

   task automatic test_back_to_back();
      ce1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; wd1 = 32'h100;
      tick();
      addr1 = 32'h4; wd1 = 32'h200;
      tick();
      addr1 = 32'h8; wd1 = 32'h300;
      tick();
      checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL b2b_st_valid: got %b want 0", vld1); end
      we1 = 1'b0; addr1 = 32'h0;
      tick();
      checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %b want 1", vld1); end
      checks++; if (rd1 !== 32'h100) begin errors++; $display("FAIL b2b_data0: got %h want 00000100", rd1); end
      checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", rdy1); end
      addr1 = 32'h4;
      tick();
      checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", vld1); end
      checks++; if (rd1 !== 32'h200) begin errors++; $display("FAIL b2b_data1: got %h want 00000200", rd1); end
      addr1 = 32'h8;
      tick();
      checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b want 1", vld1); end
      checks++; if (rd1 !== 32'h300) begin errors++; $display("FAIL b2b_data2: got %h want 00000300", rd1); end
      addr1 = 32'h6;
      tick();
      checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL b2b_mis_err: got %b want 1", err1); end
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL b2b_mis_data: got %h want 00000000", rd1); end
      ce1 = 1'b0;
      tick();
      checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b want 0", vld1); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_err: got %b want 0", err1); end
   endtask

   task automatic test_accept_in_valid_cycle();
      ce2 = 1'b1; we2 = 1'b0; addr2 = 32'h10;
      tick();
      addr2 = 32'h20;
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL avc_busy: got %b want 0", rdy2); end
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL avc_valid_first: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL avc_data_first: got %h want deadbeef", rd2); end
      checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL avc_ready: got %b want 1", rdy2); end
      tick();
      ce2 = 1'b0;
      checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL avc_gap_valid: got %b want 0", vld2); end
      checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL avc_second_busy: got %b want 0", rdy2); end
      tick();
      checks++; if (vld2 !== 1'b1) begin errors++; $display("FAIL avc_valid_second: got %b want 1", vld2); end
      checks++; if (rd2 !== 32'h1111_1111) begin errors++; $display("FAIL avc_data_second: got %h want 11111111", rd2); end
   endtask

   initial begin
      rst = 1'b0;
      ce2 = 1'b0; we2 = 1'b0; addr2 = '0; wd2 = '0;
      ce1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      test_reset();
      test_store_load();
      test_misaligned();
      test_out_of_range();
      test_reset_mid_read();
      test_back_to_back();
      test_accept_in_valid_cycle();
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
